// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one registered ALU between two requesters
module alu_share_arbiter #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               flush_i,
    input  logic [1:0]         req_valid_i,
    output logic [1:0]         req_ready_o,
    input  logic [XLEN-1:0]    req0_op_left_i,
    input  logic [XLEN-1:0]    req1_op_left_i,
    input  logic [XLEN-1:0]    req0_op_right_i,
    input  logic [XLEN-1:0]    req1_op_right_i,
    input  logic [ALUOP_W-1:0] req0_op_opcode_i,
    input  logic [ALUOP_W-1:0] req1_op_opcode_i,
    input  logic [XLEN-1:0]    req0_cmp_left_i,
    input  logic [XLEN-1:0]    req1_cmp_left_i,
    input  logic [XLEN-1:0]    req0_cmp_right_i,
    input  logic [XLEN-1:0]    req1_cmp_right_i,
    input  logic [2:0]         req0_cmp_opcode_i,
    input  logic [2:0]         req1_cmp_opcode_i,
    output logic               alu_clk_en_o,
    output logic [XLEN-1:0]    alu_op_left_o,
    output logic [XLEN-1:0]    alu_op_right_o,
    output logic [XLEN-1:0]    alu_cmp_left_o,
    output logic [XLEN-1:0]    alu_cmp_right_o,
    output logic [ALUOP_W-1:0] alu_op_opcode_o,
    output logic [2:0]         alu_cmp_opcode_o,
    input  logic [XLEN-1:0]    alu_op_result_i,
    input  logic               alu_cmp_result_i,
    output logic [1:0]         rsp_valid_o,
    input  logic [1:0]         rsp_ready_i,
    output logic [XLEN-1:0]    rsp_op_result_o,
    output logic               rsp_cmp_result_o,
    output logic               busy_o
);
    logic inflight_q, tag_q, last_q;
    logic advance, issue, sel;
    logic [1:0] grant;

    // A pending result drains in the same cycle a new operation issues.
    assign advance      = !inflight_q | rsp_ready_i[tag_q];
    assign issue        = advance & !flush_i;
    assign alu_clk_en_o = issue;

    assign sel   = (req_valid_i == 2'b11) ? !last_q : (req_valid_i == 2'b10);
    // Reset masks the grant so req_ready_o drops immediately when reset asserts.
    assign grant = (issue && !reset_i && req_valid_i != 2'b00) ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign req_ready_o = grant;

    assign alu_op_left_o    = sel ? req1_op_left_i    : req0_op_left_i;
    assign alu_op_right_o   = sel ? req1_op_right_i   : req0_op_right_i;
    assign alu_op_opcode_o  = sel ? req1_op_opcode_i  : req0_op_opcode_i;
    assign alu_cmp_left_o   = sel ? req1_cmp_left_i   : req0_cmp_left_i;
    assign alu_cmp_right_o  = sel ? req1_cmp_right_i  : req0_cmp_right_i;
    assign alu_cmp_opcode_o = sel ? req1_cmp_opcode_i : req0_cmp_opcode_i;

    assign rsp_valid_o      = inflight_q ? (tag_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_op_result_o  = alu_op_result_i;
    assign rsp_cmp_result_o = alu_cmp_result_i;
    assign busy_o           = inflight_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            inflight_q <= 1'b0;
            tag_q      <= 1'b0;
            last_q     <= 1'b1;
        end else if (flush_i) begin
            inflight_q <= 1'b0;
        end else if (advance) begin
            inflight_q <= |grant;
            if (|grant) begin
                tag_q  <= sel;
                last_q <= sel;
            end
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed checks of arbitration, back-pressure, flush and reset
module tb_alu_share_arbiter;
    localparam int XLEN = 32;
    localparam int ALUOP_W = 4;
    localparam logic [ALUOP_W-1:0] OP_ADD = 4'd0, OP_SUB = 4'd1;
    localparam logic [2:0] CMP_BLT = 3'd4, CMP_BLTU = 3'd6;

    logic clk_i = 1'b0;
    logic reset_i = 1'b1;
    logic flush_i = 1'b0;
    logic [1:0] req_valid_i = 2'b00;
    logic [1:0] req_ready_o;
    logic [XLEN-1:0] req0_op_left_i = '0, req1_op_left_i = '0;
    logic [XLEN-1:0] req0_op_right_i = '0, req1_op_right_i = '0;
    logic [ALUOP_W-1:0] req0_op_opcode_i = OP_ADD, req1_op_opcode_i = OP_ADD;
    logic [XLEN-1:0] req0_cmp_left_i = '0, req1_cmp_left_i = '0;
    logic [XLEN-1:0] req0_cmp_right_i = '0, req1_cmp_right_i = '0;
    logic [2:0] req0_cmp_opcode_i = CMP_BLT, req1_cmp_opcode_i = CMP_BLT;
    logic alu_clk_en_o;
    logic [XLEN-1:0] alu_op_left_o, alu_op_right_o, alu_cmp_left_o, alu_cmp_right_o;
    logic [ALUOP_W-1:0] alu_op_opcode_o;
    logic [2:0] alu_cmp_opcode_o;
    logic [XLEN-1:0] alu_op_result_i = '0;
    logic alu_cmp_result_i = 1'b0;
    logic [1:0] rsp_valid_o;
    logic [1:0] rsp_ready_i = 2'b11;
    logic [XLEN-1:0] rsp_op_result_o;
    logic rsp_cmp_result_o;
    logic busy_o;

    int checks = 0;
    int errors = 0;

    alu_share_arbiter #(.XLEN(XLEN), .ALUOP_W(ALUOP_W)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req0_op_left_i(req0_op_left_i), .req1_op_left_i(req1_op_left_i),
        .req0_op_right_i(req0_op_right_i), .req1_op_right_i(req1_op_right_i),
        .req0_op_opcode_i(req0_op_opcode_i), .req1_op_opcode_i(req1_op_opcode_i),
        .req0_cmp_left_i(req0_cmp_left_i), .req1_cmp_left_i(req1_cmp_left_i),
        .req0_cmp_right_i(req0_cmp_right_i), .req1_cmp_right_i(req1_cmp_right_i),
        .req0_cmp_opcode_i(req0_cmp_opcode_i), .req1_cmp_opcode_i(req1_cmp_opcode_i),
        .alu_clk_en_o(alu_clk_en_o),
        .alu_op_left_o(alu_op_left_o), .alu_op_right_o(alu_op_right_o),
        .alu_cmp_left_o(alu_cmp_left_o), .alu_cmp_right_o(alu_cmp_right_o),
        .alu_op_opcode_o(alu_op_opcode_o), .alu_cmp_opcode_o(alu_cmp_opcode_o),
        .alu_op_result_i(alu_op_result_i), .alu_cmp_result_i(alu_cmp_result_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_op_result_o(rsp_op_result_o), .rsp_cmp_result_o(rsp_cmp_result_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Registered ALU, held whenever its clock enable is low.
    always @(posedge clk_i) begin
        if (alu_clk_en_o) begin
            alu_op_result_i <= (alu_op_opcode_o == OP_SUB) ? alu_op_left_o - alu_op_right_o
                                                           : alu_op_left_o + alu_op_right_o;
            alu_cmp_result_i <= (alu_cmp_opcode_o == CMP_BLTU) ? (alu_cmp_left_o < alu_cmp_right_o)
                                : ($signed(alu_cmp_left_o) < $signed(alu_cmp_right_o));
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] r, input logic f);
        req_valid_i = v;
        rsp_ready_i = r;
        flush_i = f;
    endtask

    initial begin
        // reset state
        sample();
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
        chk("rst_req_ready", 32'(req_ready_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        next_cycle();
        reset_i = 1'b0;

        // single request on port 0: 5+7
        req0_op_left_i = 5; req0_op_right_i = 7; req0_op_opcode_i = OP_ADD;
        drive(2'b01, 2'b11, 1'b0);
        sample();
        chk("t1_grant", 32'(req_ready_o), 32'h1);
        next_cycle();
        drive(2'b00, 2'b11, 1'b0);
        sample();
        chk("t1_rsp_valid", 32'(rsp_valid_o), 32'h1);
        chk("t1_result", rsp_op_result_o, 32'd12);
        next_cycle();
        sample();
        chk("t1_busy_low", 32'(busy_o), 32'h0);

        // fresh reset so the first tie goes to port 0
        next_cycle();
        reset_i = 1'b1;
        next_cycle();
        reset_i = 1'b0;
        req0_op_left_i = 1; req0_op_right_i = 1;
        req1_op_left_i = 2; req1_op_right_i = 2; req1_op_opcode_i = OP_ADD;
        for (int k = 0; k < 5; k++) begin
            drive(k < 4 ? 2'b11 : 2'b00, 2'b11, 1'b0);
            sample();
            if (k < 4) begin
                chk($sformatf("t2_grant%0d", k), 32'(req_ready_o), (k % 2 == 0) ? 32'h1 : 32'h2);
                chk($sformatf("t2_clk_en%0d", k), 32'(alu_clk_en_o), 32'h1);
            end
            if (k > 0) begin
                chk($sformatf("t2_tag%0d", k), 32'(rsp_valid_o), (k % 2 == 1) ? 32'h1 : 32'h2);
                chk($sformatf("t2_res%0d", k), rsp_op_result_o, (k % 2 == 1) ? 32'd2 : 32'd4);
            end
            next_cycle();
        end

        // back-pressure: port 1 SUB 10-3 held while port 1 is not ready
        req1_op_left_i = 10; req1_op_right_i = 3; req1_op_opcode_i = OP_SUB;
        req0_op_left_i = 5; req0_op_right_i = 7; req0_op_opcode_i = OP_ADD;
        drive(2'b10, 2'b01, 1'b0);
        sample();
        chk("t3_grant1", 32'(req_ready_o), 32'h2);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            drive(2'b01, 2'b01, 1'b0);
            sample();
            chk($sformatf("t3_clk_en%0d", k), 32'(alu_clk_en_o), 32'h0);
            chk($sformatf("t3_ready%0d", k), 32'(req_ready_o), 32'h0);
            chk($sformatf("t3_valid%0d", k), 32'(rsp_valid_o), 32'h2);
            chk($sformatf("t3_hold%0d", k), rsp_op_result_o, 32'd7);
            next_cycle();
        end
        drive(2'b01, 2'b11, 1'b0);
        sample();
        chk("t3_drain_res", rsp_op_result_o, 32'd7);
        chk("t3_drain_grant", 32'(req_ready_o), 32'h1);
        chk("t3_drain_clk_en", 32'(alu_clk_en_o), 32'h1);
        next_cycle();
        drive(2'b00, 2'b11, 1'b0);
        sample();
        chk("t3_next_valid", 32'(rsp_valid_o), 32'h1);
        chk("t3_next_res", rsp_op_result_o, 32'd12);
        next_cycle();

        // compare path: signed vs unsigned on 0xFFFFFFFF < 1
        req0_cmp_left_i = 32'hFFFF_FFFF; req0_cmp_right_i = 1; req0_cmp_opcode_i = CMP_BLT;
        drive(2'b01, 2'b11, 1'b0);
        sample();
        chk("t4_grant_blt", 32'(req_ready_o), 32'h1);
        next_cycle();
        req0_cmp_opcode_i = CMP_BLTU;
        sample();
        chk("t4_blt", 32'(rsp_cmp_result_o), 32'h1);
        chk("t4_grant_bltu", 32'(req_ready_o), 32'h1);
        next_cycle();
        drive(2'b00, 2'b11, 1'b0);
        sample();
        chk("t4_bltu", 32'(rsp_cmp_result_o), 32'h0);
        next_cycle();

        // flush with port 1 in flight and nobody accepting
        drive(2'b10, 2'b00, 1'b0);
        sample();
        chk("t5_grant1", 32'(req_ready_o), 32'h2);
        next_cycle();
        drive(2'b01, 2'b00, 1'b1);
        sample();
        chk("t5_flush_ready", 32'(req_ready_o), 32'h0);
        chk("t5_flush_clk_en", 32'(alu_clk_en_o), 32'h0);
        chk("t5_flush_visible", 32'(rsp_valid_o), 32'h2);
        next_cycle();
        drive(2'b01, 2'b00, 1'b0);
        sample();
        chk("t5_post_valid", 32'(rsp_valid_o), 32'h0);
        chk("t5_post_grant", 32'(req_ready_o), 32'h1);
        next_cycle();
        drive(2'b00, 2'b11, 1'b0);
        sample();
        chk("t5_p0_res", rsp_op_result_o, 32'd12);
        next_cycle();

        // asynchronous reset mid-operation
        req0_op_left_i = 1; req0_op_right_i = 1; req0_op_opcode_i = OP_ADD;
        drive(2'b11, 2'b00, 1'b0);
        next_cycle();
        sample();
        chk("t6_busy", 32'(busy_o), 32'h1);
        #2 reset_i = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(rsp_valid_o), 32'h0);
        chk("t6_rst_ready", 32'(req_ready_o), 32'h0);
        chk("t6_rst_busy", 32'(busy_o), 32'h0);
        next_cycle();
        reset_i = 1'b0;
        drive(2'b11, 2'b11, 1'b0);
        sample();
        chk("t6_tie_grant", 32'(req_ready_o), 32'h1);
        next_cycle();
        drive(2'b00, 2'b11, 1'b0);
        sample();
        chk("t6_rsp_valid", 32'(rsp_valid_o), 32'h1);
        chk("t6_res", rsp_op_result_o, 32'd2);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one registered ALU (1-cycle latency, gated by its clock enable) between two requesters, e.g. the execute stage (port 0) and the address/CSR helper (port 1).
- Each requester gets a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin, muxes operands and opcodes into the ALU, and drives the ALU clock enable.
- It tracks the one in-flight operation and holds the ALU output register stable until the owning requester accepts the result.

Parameters:
- XLEN, 32, datapath width of operands and results.
- ALUOP_W, 4, width of the ALU operation opcode.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous reset, active-high
- flush_i  in  1  kill any in-flight operation and block new grants this cycle
- req_valid_i  in  2  request valid per requester
- req_ready_o  out  2  request accepted, one-hot or zero
- req0_op_left_i, req1_op_left_i  in  XLEN  left operand
- req0_op_right_i, req1_op_right_i  in  XLEN  right operand
- req0_op_opcode_i, req1_op_opcode_i  in  ALUOP_W  ALU operation
- req0_cmp_left_i, req1_cmp_left_i  in  XLEN  comparator left
- req0_cmp_right_i, req1_cmp_right_i  in  XLEN  comparator right
- req0_cmp_opcode_i, req1_cmp_opcode_i  in  3  comparator condition
- alu_clk_en_o  out  1  ALU clock enable
- alu_op_left_o, alu_op_right_o, alu_cmp_left_o, alu_cmp_right_o  out  XLEN  muxed operands
- alu_op_opcode_o  out  ALUOP_W  muxed opcode
- alu_cmp_opcode_o  out  3  muxed condition
- alu_op_result_i  in  XLEN  ALU registered result
- alu_cmp_result_i  in  1  ALU registered compare result
- rsp_valid_o  out  2  response valid, at most one bit set
- rsp_ready_i  in  2  response accepted per requester
- rsp_op_result_o  out  XLEN  equals alu_op_result_i
- rsp_cmp_result_o  out  1  equals alu_cmp_result_i
- busy_o  out  1  equals inflight_q

Behaviour:
- State registers:
  - inflight_q: one operation resides in the ALU output register.
  - tag_q: owner of that operation.
  - last_q: last granted requester.
- Reset values (asynchronous, while reset_i high): inflight_q=0, tag_q=0, last_q=1 (port 0 wins the first tie). Consequently rsp_valid_o=0, req_ready_o=0, busy_o=0.
- Reset asserted mid-operation drops the operation; no response is ever produced for it.
- advance = !inflight_q | rsp_ready_i[tag_q].
  - A pending result is drained in the same cycle a new operation issues (full throughput).
- alu_clk_en_o = advance & !flush_i.
  - When low, the ALU output register holds, so an unaccepted result stays stable indefinitely.
- Grant:
  - Only when advance & !flush_i.
  - If exactly one request is valid, grant it.
  - If both are valid, grant !last_q.
  - req_ready_o is the one-hot grant, purely combinational from current inputs and state.
- Operand mux:
  - alu_* outputs select the requester with valid high.
  - If both are valid, select !last_q.
  - If neither is valid, select port 0.
  - Outputs are don't-care when no grant.
- On grant to requester g at clock edge: inflight_q<=1, tag_q<=g, last_q<=g.
- advance with no grant: inflight_q<=0. The ALU loads don't-care data, which is harmless.
- No advance: all state holds.
- Responses:
  - rsp_valid_o[tag_q] = inflight_q; the other bit is 0.
  - The result becomes visible exactly 1 cycle after the request handshake.
  - Handshake completes on rsp_valid_o & rsp_ready_i.
  - rsp_ready_i of the non-owning requester is ignored.
- flush_i:
  - At the next edge: inflight_q<=0, regardless of rsp_ready_i.
  - No grant in the flush cycle; last_q is unchanged.
  - rsp_valid_o stays combinationally visible during the flush cycle. A consumer accepting it that cycle is legal and harmless.
- Requesters must hold request payload stable while valid and not ready. The arbiter does not register operands.
- Starvation bound: with both requesters continuously valid and responses always accepted, grants alternate 0,1,0,1.

Test Plan:
- Reset then single request, port 0: op_left=5, op_right=7, ADD, rsp_ready_i=11.
  - Expect req_ready_o=01 in cycle 0.
  - Expect rsp_valid_o=01 with result 12 in cycle 1.
  - Expect busy_o low in cycle 2 with no further requests.
- Both ports valid every cycle with distinct ADD operands (0:1+1, 1:2+2), rsp_ready_i=11.
  - Expect grants 01,10,01,10.
  - Expect results 2,4,2,4 with matching rsp_valid_o tags.
  - Expect one operation per cycle.
- Back-pressure: port 1 issues SUB 10-3 with rsp_ready_i[1]=0 for 4 cycles while port 0 stays valid.
  - Expect alu_clk_en_o=0 and req_ready_o=00 for 4 cycles.
  - Expect rsp_op_result_o held at 7 throughout.
  - On release, port 0 is granted in the same cycle the result drains.
- Compare path: port 0 BLT with cmp_left=0xFFFFFFFF, cmp_right=1 -> rsp_cmp_result_o=1 one cycle later. Same operands with BLTU -> 0.
- Flush: port 1 operation in flight, rsp_ready_i=00, flush_i pulsed 1 cycle with port 0 valid.
  - Expect no grant in the flush cycle.
  - Expect rsp_valid_o=00 next cycle.
  - Expect port 0 granted the cycle after.
- Asynchronous reset asserted mid-cycle with inflight_q=1 -> rsp_valid_o, req_ready_o, busy_o drop to 0 immediately, before the next edge. After release, a tie grants port 0.
